// File: rtl/multi_pulse_gen.sv
`timescale 1ns/1ps
// N-channel button-to-pulse generator: sync chain, debouncer, press FSM, pulse/toggle output, press counter.
// Latency SYNC_STAGES + DEBOUNCE_CYCLES + 2 clocks from sampling edge to led_po; no backpressure.
module multi_pulse_gen #(
  parameter int N_CH            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 1,
  parameter int CNT_W           = 8
) (
  input  logic             clk_pi,
  input  logic             rst_n_pi,
  input  logic [N_CH-1:0]  button_pi,
  input  logic [N_CH-1:0]  mode_pi,
  output logic [N_CH-1:0]  led_po,
  output logic [N_CH-1:0]  busy_po,
  output logic [CNT_W-1:0] press_cnt_po
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW_W-1:0] PW_LOAD = PW_W'(PULSE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [PW_W-1:0] PW_ONE  = PW_W'(1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  logic [N_CH-1:0]  press_acc;
  logic [CNT_W-1:0] press_inc;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   d_q;
    logic                   d_prev_q;
    logic                   press;
    logic [DB_W-1:0]        db_cnt_q;
    logic [PW_W-1:0]        pw_cnt_q;
    logic                   toggle_q;
    logic                   led_q;
    logic                   busy_q;
    state_t                 state_q;

    assign s     = sync_q[SYNC_STAGES-1];
    assign press = d_q & ~d_prev_q;

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], button_pi[g]};
      end
    end

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
        d_q      <= 1'b0;
        d_prev_q <= 1'b0;
        db_cnt_q <= '0;
      end else begin
        d_prev_q <= d_q;
        if (s == d_q) begin
          db_cnt_q <= '0;
        end else if (db_cnt_q == DB_LAST) begin
          d_q      <= s;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DB_ONE;
        end
      end
    end

    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
      if (!rst_n_pi) begin
        state_q  <= IDLE;
        pw_cnt_q <= '0;
        toggle_q <= 1'b0;
        led_q    <= 1'b0;
        busy_q   <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (press) begin
              state_q  <= PULSE;
              pw_cnt_q <= PW_LOAD;
              if (mode_pi[g]) toggle_q <= ~toggle_q;
            end
          end
          PULSE: begin
            if (pw_cnt_q == '0) state_q <= WAIT_REL;
            else                pw_cnt_q <= pw_cnt_q - PW_ONE;
          end
          WAIT_REL: begin
            if (!d_q) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
        // Output mux looks at the current state, so mode changes show up one clock later.
        led_q  <= mode_pi[g] ? toggle_q : (state_q == PULSE);
        busy_q <= (state_q != IDLE);
      end
    end

    assign press_acc[g] = press && (state_q == IDLE);
    assign led_po[g]    = led_q;
    assign busy_po[g]   = busy_q;
  end

  always_comb begin
    press_inc = '0;
    for (int i = 0; i < N_CH; i++) begin
      press_inc = press_inc + CNT_W'(press_acc[i]);
    end
  end

  always_ff @(posedge clk_pi or negedge rst_n_pi) begin
    if (!rst_n_pi) begin
      press_cnt_po <= '0;
    end else begin
      press_cnt_po <= press_cnt_po + press_inc;
    end
  end

endmodule

// File: tb/tb_multi_pulse_gen.sv
`timescale 1ns/1ps
// Directed bench for multi_pulse_gen: table of press scenarios plus reset-mid-pulse and mode-change sequences.
module tb_multi_pulse_gen;

  localparam int N_CH = 4;
  localparam int CNT_W = 4;
  localparam int REL = 30;

  logic             clk;
  logic             rst_n;
  logic [N_CH-1:0]  button;
  logic [N_CH-1:0]  mode;
  logic [N_CH-1:0]  led;
  logic [N_CH-1:0]  busy;
  logic [CNT_W-1:0] cnt;

  int checks = 0;
  int failures = 0;

  multi_pulse_gen #(
    .N_CH(N_CH), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .PULSE_CYCLES(3), .CNT_W(CNT_W)
  ) dut (
    .clk_pi(clk), .rst_n_pi(rst_n), .button_pi(button), .mode_pi(mode),
    .led_po(led), .busy_po(busy), .press_cnt_po(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] btn;
    logic [3:0] mode;
    int         hold;
    int         ref_ch;
    int         exp_first;
    int         exp_hi;
    logic [3:0] exp_busy_hold;
    int         exp_bfall;
    logic [3:0] exp_led_end;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    int first, hi, bfall;
    logic [3:0] start, busy_hold;

    rst_n  = 1'b0;
    button = '0;
    mode   = '0;

    // Cycle c = sample taken 1ns after the c-th edge, edge 1 being the first to see the new button level.
    //          rst   btn      mode     hold ref first hi  bhold    bfall ledend   cnt
    vecs[0] = '{1'b1, 4'b0010, 4'b0000,   3, 1,  -1,  0, 4'b0000,    4, 4'b0000, 0};
    vecs[1] = '{1'b0, 4'b0001, 4'b0000,  20, 0,   8,  3, 4'b0001,   28, 4'b0000, 1};
    vecs[2] = '{1'b1, 4'b0100, 4'b0100,  20, 2,   8, 43, 4'b0100,   28, 4'b0100, 1};
    vecs[3] = '{1'b0, 4'b0100, 4'b0100,  20, 2,   8,  7, 4'b0100,   28, 4'b0000, 2};
    vecs[4] = '{1'b1, 4'b1111, 4'b0000,  20, 0,   8,  3, 4'b1111,   28, 4'b0000, 4};
    vecs[5] = '{1'b0, 4'b1111, 4'b0000,  20, 1,   8,  3, 4'b1111,   28, 4'b0000, 8};
    vecs[6] = '{1'b0, 4'b1111, 4'b0000,  20, 2,   8,  3, 4'b1111,   28, 4'b0000, 12};
    vecs[7] = '{1'b0, 4'b1111, 4'b0000,  20, 3,   8,  3, 4'b1111,   28, 4'b0000, 0};
    vecs[8] = '{1'b1, 4'b1000, 4'b0000, 100, 3,   8,  3, 4'b1000,  108, 4'b0000, 1};

    do_reset();
    chk("reset_led", int'(led), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_cnt", int'(cnt), 0);

    for (int v = 0; v < 9; v++) begin
      if (vecs[v].rst) do_reset();
      mode   = vecs[v].mode;
      start  = led & vecs[v].btn;
      button = vecs[v].btn;
      first = -1; hi = 0; bfall = -1; busy_hold = '0;
      for (int c = 1; c <= vecs[v].hold + REL; c++) begin
        tick();
        if (first < 0 && ((led & vecs[v].btn) != start)) first = c;
        if (led[vecs[v].ref_ch]) hi++;
        if (c > vecs[v].hold && bfall < 0 && ((busy & vecs[v].btn) == 4'b0000)) bfall = c;
        if (c == vecs[v].hold) begin
          busy_hold = busy;
          button = '0;
        end
      end
      chk($sformatf("v%0d_first_change", v), first, vecs[v].exp_first);
      chk($sformatf("v%0d_high_cycles", v), hi, vecs[v].exp_hi);
      chk($sformatf("v%0d_busy_held", v), int'(busy_hold), int'(vecs[v].exp_busy_hold));
      chk($sformatf("v%0d_busy_fall", v), bfall, vecs[v].exp_bfall);
      chk($sformatf("v%0d_led_end", v), int'(led), int'(vecs[v].exp_led_end));
      chk($sformatf("v%0d_cnt", v), int'(cnt), vecs[v].exp_cnt);
    end

    // Reset asserted on the 2nd pulse clock of ch0 while the button stays held.
    do_reset();
    mode   = '0;
    button = 4'b0001;
    for (int c = 1; c <= 9; c++) tick();
    chk("rmp_led_before", int'(led), 1);
    chk("rmp_cnt_before", int'(cnt), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rmp_led_async", int'(led), 0);
    chk("rmp_busy_async", int'(busy), 0);
    chk("rmp_cnt_async", int'(cnt), 0);
    tick();
    tick();
    rst_n = 1'b1;
    first = -1; hi = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (first < 0 && led[0]) first = c;
      if (led[0]) hi++;
    end
    chk("rmp_first", first, 8);
    chk("rmp_high_cycles", hi, 3);
    chk("rmp_cnt_after", int'(cnt), 1);
    chk("rmp_busy_held", int'(busy), 1);
    button = '0;
    for (int c = 1; c <= REL; c++) tick();
    chk("rmp_busy_released", int'(busy), 0);

    // Mode change on a toggled channel: one clock to take effect, toggle state retained.
    do_reset();
    mode   = 4'b0010;
    button = 4'b0010;
    for (int c = 1; c <= 20; c++) tick();
    button = '0;
    for (int c = 1; c <= REL; c++) tick();
    chk("mc_toggle_on", int'(led), 2);
    mode = 4'b0000;
    #1;
    chk("mc_before_edge", int'(led), 2);
    tick();
    chk("mc_pulse_mode", int'(led), 0);
    mode = 4'b0010;
    tick();
    chk("mc_toggle_kept", int'(led), 2);
    chk("mc_cnt", int'(cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
